// File: rtl/fme_satd_cmp.sv
// Sub-pel candidate selector: accumulates 4x4 SATDs per candidate, adds the MV
// cost and keeps the lowest-cost candidate (earliest wins on ties).
module fme_satd_cmp #(
  parameter int SATD_BITS = 15,
  parameter int COST_BITS = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [4:0]           blk_num_i,
  input  logic [3:0]           cand_num_i,
  input  logic [SATD_BITS-1:0] satd_4x4_i,
  input  logic                 satd_4x4_valid_i,
  input  logic [COST_BITS-1:0] mv_cost_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [3:0]           best_idx_o,
  output logic [COST_BITS-1:0] best_cost_o
);

  typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;

  localparam logic [COST_BITS-1:0] COST_MAX = '1;

  state_t               state, state_nxt;
  logic [4:0]           blk_num, blk_cnt, blk_norm;
  logic [3:0]           cand_num, cand_idx, cand_norm;
  logic [COST_BITS-1:0] acc, cand_cost, satd_ext, acc_sum, cost_sum;
  logic                 blk_vld, blk_last, cand_last;

  function automatic logic [COST_BITS-1:0] sat_add(input logic [COST_BITS-1:0] a,
                                                   input logic [COST_BITS-1:0] b);
    logic [COST_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COST_BITS] ? COST_MAX : s[COST_BITS-1:0];
  endfunction

  assign blk_norm  = (blk_num_i == 5'd0 || blk_num_i > 5'd16) ? 5'd16 : blk_num_i;
  assign cand_norm = (cand_num_i == 4'd0) ? 4'd1 :
                     (cand_num_i > 4'd9)  ? 4'd9 : cand_num_i;

  assign satd_ext  = {{(COST_BITS-SATD_BITS){1'b0}}, satd_4x4_i};
  assign acc_sum   = sat_add(acc, satd_ext);
  assign cost_sum  = sat_add(acc_sum, mv_cost_i);

  // Valids in CMP belong to the next candidate, so both ACC and CMP accumulate.
  assign blk_vld   = satd_4x4_valid_i && (state == ACC || state == CMP);
  assign blk_last  = blk_vld && ((blk_cnt + 5'd1) == blk_num);
  assign cand_last = (cand_idx == (cand_num - 4'd1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_i) state_nxt = ACC;
      ACC:  if (blk_last) state_nxt = CMP;
      CMP: begin
        if (cand_last)     state_nxt = DONE;
        else if (!blk_last) state_nxt = ACC;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      blk_num     <= '0;
      cand_num    <= '0;
      blk_cnt     <= '0;
      cand_idx    <= '0;
      acc         <= '0;
      cand_cost   <= '0;
      best_idx_o  <= '0;
      best_cost_o <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        blk_num  <= blk_norm;
        cand_num <= cand_norm;
        blk_cnt  <= '0;
        cand_idx <= '0;
        acc      <= '0;
      end else if (blk_vld) begin
        if (blk_last) begin
          cand_cost <= cost_sum;
          acc       <= '0;
          blk_cnt   <= '0;
        end else begin
          acc     <= acc_sum;
          blk_cnt <= blk_cnt + 5'd1;
        end
      end
      // cand_cost here is the value loaded on the previous edge.
      if (state == CMP) begin
        if (cand_idx == 4'd0 || cand_cost < best_cost_o) begin
          best_idx_o  <= cand_idx;
          best_cost_o <= cand_cost;
        end
        cand_idx <= cand_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fme_satd_cmp.sv
// Bench for fme_satd_cmp: table of searches with hand-derived results, scoreboard
// queue popped on done_o, plus reset-abort and model-checked random search.
module tb_fme_satd_cmp;

  localparam int SB = 15;
  localparam int CB = 20;
  localparam longint CMAX = (64'd1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4:0]    blk_num_i;
  logic [3:0]    cand_num_i;
  logic [SB-1:0] satd;
  logic          satd_vld;
  logic [CB-1:0] mv_cost;
  logic          busy, done;
  logic [3:0]    best_idx;
  logic [CB-1:0] best_cost;

  fme_satd_cmp #(.SATD_BITS(SB), .COST_BITS(CB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .blk_num_i(blk_num_i),
    .cand_num_i(cand_num_i), .satd_4x4_i(satd), .satd_4x4_valid_i(satd_vld),
    .mv_cost_i(mv_cost), .busy_o(busy), .done_o(done), .best_idx_o(best_idx),
    .best_cost_o(best_cost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    idx;
    logic [CB-1:0] cost;
  } exp_t;

  typedef struct {
    int blk_in, cand_in, nblk, ncand, gap;
    bit stray;
    logic [8:0][15:0]   satd;
    logic [8:0][CB-1:0] mv;
    int exp_idx, exp_cost;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_satd [9][16];
  int   cur_mv   [9];
  vec_t tbl [9];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every done_o pulse must match the oldest outstanding search.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("best_idx", best_idx, e.idx);
        chk("best_cost", best_cost, e.cost);
      end
    end
  end

  function automatic vec_t mk(int bi, int ci, int nb, int nc, int gap, bit stray,
                              int s, int m, int ei, int ec);
    vec_t v;
    v.blk_in = bi; v.cand_in = ci; v.nblk = nb; v.ncand = nc; v.gap = gap;
    v.stray = stray; v.exp_idx = ei; v.exp_cost = ec;
    for (int i = 0; i < 9; i++) begin
      v.satd[i] = 16'(s);
      v.mv[i]   = CB'(m);
    end
    return v;
  endfunction

  // Independent reference: full-width sum then clamp (all terms are non-negative).
  function automatic exp_t model(int nblk, int ncand);
    exp_t   r;
    longint t, best;
    best = 0; r.idx = '0;
    for (int c = 0; c < ncand; c++) begin
      t = cur_mv[c];
      for (int b = 0; b < nblk; b++) t += cur_satd[c][b];
      if (t > CMAX) t = CMAX;
      if (c == 0 || t < best) begin
        best  = t;
        r.idx = 4'(c);
      end
    end
    r.cost = CB'(best);
    return r;
  endfunction

  // Entered and left at posedge+1.
  task automatic run_search(int blk_in, int cand_in, int nblk, int ncand, int gap, bit stray);
    start = 1'b1; blk_num_i = 5'(blk_in); cand_num_i = 4'(cand_in);
    if (stray) begin
      satd_vld = 1'b1; satd = 15'd500;
    end
    @(posedge clk); #1;
    start = 1'b0; satd_vld = 1'b0;
    for (int c = 0; c < ncand; c++) begin
      for (int b = 0; b < nblk; b++) begin
        repeat (gap) begin @(posedge clk); #1; end
        satd_vld = 1'b1;
        satd     = 15'(cur_satd[c][b]);
        mv_cost  = CB'(cur_mv[c]);
        if (stray && c == 0 && b == 1) begin
          start = 1'b1; blk_num_i = 5'd3; cand_num_i = 4'd2;
        end
        @(posedge clk); #1;
        satd_vld = 1'b0; start = 1'b0;
      end
    end
    @(negedge clk);
    chk("cmp_cycle_done", done, 0);
    chk("cmp_cycle_busy", busy, 1);
    @(negedge clk);
    chk("latency_done", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; blk_num_i = '0; cand_num_i = '0;
    satd = '0; satd_vld = 1'b0; mv_cost = '0;

    tbl[0] = mk(1, 1, 1, 1, 3, 0, 100, 5, 0, 105);
    tbl[1] = mk(16, 9, 16, 9, 3, 0, 10, 0, 8, 186);
    for (int i = 0; i < 9; i++) tbl[1].mv[i] = CB'(50 - i * 3);
    tbl[2] = mk(4, 4, 4, 4, 1, 1, 0, 0, 0, 200);
    tbl[2].satd[0] = 50; tbl[2].mv[0] = 0;
    tbl[2].satd[1] = 45; tbl[2].mv[1] = 20;
    tbl[2].satd[2] = 40; tbl[2].mv[2] = 40;
    tbl[2].satd[3] = 30; tbl[2].mv[3] = 80;
    tbl[3] = mk(16, 1, 16, 1, 2, 0, 32767, 1048575, 0, 1048575);
    tbl[4] = mk(2, 2, 2, 2, 0, 0, 7, 3, 1, 9);
    tbl[4].satd[1] = 4; tbl[4].mv[1] = 1;
    tbl[5] = mk(0, 0, 16, 1, 1, 0, 1, 2, 0, 18);
    tbl[6] = mk(1, 12, 1, 9, 2, 0, 0, 0, 8, 50);
    for (int i = 0; i < 9; i++) tbl[6].satd[i] = 16'(90 - 5 * i);
    tbl[7] = mk(1, 3, 1, 3, 0, 0, 30, 0, 1, 20);
    tbl[7].satd[1] = 20; tbl[7].satd[2] = 25;
    tbl[8] = mk(2, 3, 2, 3, 1, 1, 40, 0, 1, 60);
    tbl[8].satd[1] = 30; tbl[8].satd[2] = 30;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", best_idx, 0);
    chk("rst_cost", best_cost, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      for (int c = 0; c < 9; c++) begin
        cur_mv[c] = int'(tbl[v].mv[c]);
        for (int b = 0; b < 16; b++) cur_satd[c][b] = int'(tbl[v].satd[c]);
      end
      e.idx = 4'(tbl[v].exp_idx); e.cost = CB'(tbl[v].exp_cost);
      sbq.push_back(e);
      run_search(tbl[v].blk_in, tbl[v].cand_in, tbl[v].nblk, tbl[v].ncand,
                 tbl[v].gap, tbl[v].stray);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset during the 3rd block of candidate 1; candidate 0 already set best_cost=40.
    start = 1'b1; blk_num_i = 5'd4; cand_num_i = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      satd_vld = 1'b1; satd = 15'd10; mv_cost = '0;
      @(posedge clk); #1 satd_vld = 1'b0;
    end
    @(posedge clk); #1;
    satd_vld = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_idx", best_idx, 0);
    chk("abort_cost", best_cost, 0);
    @(posedge clk); #1 satd_vld = 1'b0; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_abort_busy", busy, 0);
    @(posedge clk); #1;

    for (int c = 0; c < 9; c++) begin
      cur_mv[c] = int'($urandom_range(500, 0));
      for (int b = 0; b < 16; b++) cur_satd[c][b] = int'($urandom_range(2000, 0));
    end
    sbq.push_back(model(5, 4));
    run_search(5, 4, 5, 4, 2, 0);
    repeat (5) @(posedge clk);

    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fme_satd_cmp.md
FME_SATD_CMP -- requirements
Module: fme_satd_cmp

Interface
REQ-001 Parameter SATD_BITS, default 15, width of the incoming 4x4 SATD (matches satd_gen_4x4 output at 8-bit depth).
REQ-002 Parameter COST_BITS, default 20, width of the accumulated cost, MV cost and best cost.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  single-cycle pulse that begins one candidate search.
REQ-006 blk_num_i  input  5  number of 4x4 blocks per candidate, 1..16; 0 means 16.
REQ-007 cand_num_i  input  4  number of sub-pel candidates, 1..9; 0 means 1, values above 9 mean 9.
REQ-008 satd_4x4_i  input  SATD_BITS  4x4 SATD from the upstream satd_gen_4x4 stage.
REQ-009 satd_4x4_valid_i  input  1  qualifies satd_4x4_i for one cycle.
REQ-010 mv_cost_i  input  COST_BITS  MV cost of the current candidate, sampled with that candidate's last valid block.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 done_o  output  1  one-cycle pulse when best_idx_o and best_cost_o are final.
REQ-013 best_idx_o  output  4  index (0-based, arrival order) of the lowest-cost candidate.
REQ-014 best_cost_o  output  COST_BITS  cost of that candidate.

Function
REQ-015 The FSM SHALL have four states (IDLE, ACC, CMP, DONE), with done_o = (state==DONE) and no combinational path from inputs.
REQ-016 In IDLE, start_i SHALL latch blk_num_i and cand_num_i (after normalisation), clear the accumulator, the block counter and the candidate index, and enter ACC.
REQ-017 start_i outside IDLE SHALL be ignored, and satd_4x4_valid_i in IDLE or DONE SHALL be ignored.
REQ-018 In ACC and CMP, each valid SHALL add satd_4x4_i, zero-extended, to the accumulator and increment the block counter.
REQ-019 On the valid that completes blk_num blocks, the block SHALL:
- load cand_cost = acc + satd_4x4_i + mv_cost_i;
- clear the accumulator and block counter in the same edge;
- enter CMP, or stay in CMP if it is already there.
REQ-020 All additions SHALL saturate at 2^COST_BITS-1 with no wrap-around.
REQ-021 In CMP, the best registers SHALL take cand_cost and the candidate index when the candidate index is 0 or cand_cost < best_cost_o (strict, so the earliest candidate wins on ties).
REQ-022 In CMP, the candidate index SHALL then increment, and the FSM SHALL go to DONE if this was the last candidate, otherwise back to ACC.
REQ-023 A valid arriving in the CMP cycle SHALL count as a block of the next candidate.
REQ-024 Two consecutive valids (back-to-back) SHALL both be accepted; upstream normally spaces them 4 cycles apart.
REQ-025 Latency: the last valid is sampled at edge k; CMP occupies cycle k+1; done_o is high during cycle k+2 (2 cycles after the last valid).
REQ-026 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-027 best_idx_o and best_cost_o SHALL hold their values until the CMP of candidate 0 in the next search.

Reset
REQ-028 While rst_n_i is low, the block SHALL hold the state at IDLE, every register at 0, and every output at 0.
REQ-029 Reset asserted mid-search SHALL abort the search immediately; after release the block SHALL wait in IDLE for start_i with no pending done_o.

Verification
REQ-030 Single candidate: blk_num=1, cand_num=1, satd=100, mv_cost=5 -> done_o 2 cycles after the valid; best_idx=0, best_cost=105.
REQ-031 Nine candidates, 16 blocks each, every block satd=10, candidate i mv_cost=50-i*3 -> best_idx=8, best_cost=186, exactly one done_o.
REQ-032 Tie: 4 candidates, all totals 200 -> best_idx=0 (earliest wins).
REQ-033 Saturation: COST_BITS=20, 16 blocks of satd=32767 plus mv_cost=2^20-1 -> best_cost=1048575, with no wrap.
REQ-034 Spacing and stray inputs:
- back-to-back valids with 2 candidates of blk_num=2 give correct totals;
- start_i pulsed during ACC is ignored;
- valid in IDLE is ignored.
REQ-035 Reset mid-search: rst_n_i low in the 3rd block of candidate 1 -> busy_o=0 and outputs 0; a fresh search afterwards matches the reference model.
